// File: rtl/nmea_checksum_ctrl_if.sv
// rtl/nmea_checksum_ctrl_if.sv - byte stream and verdict bundle for the NMEA checksum checker
interface nmea_checksum_ctrl_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       busy;
   logic       done;
   logic [1:0] err;
   logic [7:0] calc_sum;
   logic [7:0] rx_sum;

   // byte source side
   modport master (
      output in_valid, in_data,
      input  busy, done, err, calc_sum, rx_sum
   );

   // checker side
   modport slave (
      input  in_valid, in_data,
      output busy, done, err, calc_sum, rx_sum
   );
endinterface

// File: rtl/nmea_checksum_ctrl.sv
// rtl/nmea_checksum_ctrl.sv - NMEA sentence checksum verifier; optional CR/LF check via NMEA_CRLF_CHECK_EN
module nmea_checksum_ctrl #(
   parameter int MAX_LEN = 82
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nmea_checksum_ctrl_if.slave  bus
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_SUM    = 2'd1;
   localparam logic [1:0] ERR_HEX    = 2'd2;
   localparam logic [1:0] ERR_FORMAT = 2'd3;

`ifdef NMEA_CRLF_CHECK_EN
   typedef enum logic [2:0] {
      S_IDLE, S_BODY, S_CK_HI, S_CK_LO, S_EOL, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_BODY, S_CK_HI, S_CK_LO, S_DONE
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [7:0]         calc_q, calc_d;
   logic [7:0]         rx_q, rx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [1:0]         err_q, err_d;
`ifdef NMEA_CRLF_CHECK_EN
   // EOL is one state; this flag remembers whether the CR has been seen
   logic               cr_seen_q, cr_seen_d;
`endif

   logic [LEN_W-1:0]   len_inc;
   logic               len_over;
   logic [4:0]         hex;

   // {valid, nibble} for one uppercase ASCII hex digit
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [7:0] d;
      d = 8'h00;
      if (b >= 8'h30 && b <= 8'h39) begin
         d = b - 8'h30;
         return {1'b1, d[3:0]};
      end else if (b >= 8'h41 && b <= 8'h46) begin
         d = b - 8'h37;
         return {1'b1, d[3:0]};
      end
      return 5'b0_0000;
   endfunction

   // the byte that would push the length past MAX_LEN ends the sentence
   assign len_over = (len_q == LEN_W'(MAX_LEN));
   assign len_inc  = len_over ? len_q : len_q + LEN_W'(1);
   assign hex      = hex_decode(bus.in_data);

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         calc_q    <= 8'h00;
         rx_q      <= 8'h00;
         len_q     <= '0;
         err_q     <= ERR_OK;
`ifdef NMEA_CRLF_CHECK_EN
         cr_seen_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         calc_q    <= calc_d;
         rx_q      <= rx_d;
         len_q     <= len_d;
         err_q     <= err_d;
`ifdef NMEA_CRLF_CHECK_EN
         cr_seen_q <= cr_seen_d;
`endif
      end
   end

   // next-state and datapath update for each accepted byte
   always_comb begin
      state_d   = state_q;
      calc_d    = calc_q;
      rx_d      = rx_q;
      len_d     = len_q;
      err_d     = err_q;
`ifdef NMEA_CRLF_CHECK_EN
      cr_seen_d = cr_seen_q;
`endif

      // DONE lasts one cycle whether or not a byte arrives
      if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end

      if (bus.in_valid) begin
         if (bus.in_data == CH_DOLLAR) begin
            // '$' always starts a fresh sentence, silently dropping any open one
            state_d   = S_BODY;
            calc_d    = 8'h00;
            rx_d      = 8'h00;
            len_d     = LEN_W'(1);
`ifdef NMEA_CRLF_CHECK_EN
            cr_seen_d = 1'b0;
`endif
         end else begin
            case (state_q)
               S_BODY: begin
                  len_d = len_inc;
                  if (len_over) begin
                     state_d = S_DONE;
                     err_d   = ERR_FORMAT;
                  end else if (bus.in_data == CH_STAR) begin
                     state_d = S_CK_HI;
                  end else if (bus.in_data == CH_CR || bus.in_data == CH_LF) begin
                     state_d = S_DONE;
                     err_d   = ERR_FORMAT;
                  end else begin
                     calc_d = calc_q ^ bus.in_data;
                  end
               end
               S_CK_HI: begin
                  len_d = len_inc;
                  if (len_over) begin
                     state_d = S_DONE;
                     err_d   = ERR_FORMAT;
                  end else if (!hex[4]) begin
                     state_d = S_DONE;
                     err_d   = ERR_HEX;
                  end else begin
                     rx_d[7:4] = hex[3:0];
                     state_d   = S_CK_LO;
                  end
               end
               S_CK_LO: begin
                  len_d = len_inc;
                  if (len_over) begin
                     state_d = S_DONE;
                     err_d   = ERR_FORMAT;
                  end else if (!hex[4]) begin
                     state_d = S_DONE;
                     err_d   = ERR_HEX;
                  end else begin
                     rx_d[3:0] = hex[3:0];
`ifdef NMEA_CRLF_CHECK_EN
                     state_d   = S_EOL;
`else
                     state_d   = S_DONE;
                     err_d     = (calc_q == {rx_q[7:4], hex[3:0]}) ? ERR_OK : ERR_SUM;
`endif
                  end
               end
`ifdef NMEA_CRLF_CHECK_EN
               // the terminator is not part of the length limit; counter still saturates
               S_EOL: begin
                  len_d = len_inc;
                  if (!cr_seen_q) begin
                     if (bus.in_data == CH_CR) begin
                        cr_seen_d = 1'b1;
                     end else begin
                        state_d = S_DONE;
                        err_d   = ERR_FORMAT;
                     end
                  end else begin
                     state_d = S_DONE;
                     if (bus.in_data == CH_LF) begin
                        err_d = (calc_q == rx_q) ? ERR_OK : ERR_SUM;
                     end else begin
                        err_d = ERR_FORMAT;
                     end
                  end
               end
`endif
               default: begin
                  // IDLE and DONE ignore everything except '$'
               end
            endcase
         end
      end
   end

   // outputs decoded from state and registers
   always_comb begin
      bus.busy     = (state_q != S_IDLE);
      bus.done     = (state_q == S_DONE);
      bus.err      = err_q;
      bus.calc_sum = calc_q;
      bus.rx_sum   = rx_q;
   end

endmodule

// File: tb/tb_nmea_checksum_ctrl.sv
// tb/tb_nmea_checksum_ctrl.sv - scoreboard bench for nmea_checksum_ctrl
module tb_nmea_checksum_ctrl;

   localparam int MAX_LEN = 8;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   typedef struct {
      logic [1:0] e;
      logic [7:0] c;
      logic [7:0] r;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t exp_q[$];
   string hex_digits;

   nmea_checksum_ctrl_if bus ();

   nmea_checksum_ctrl #(.MAX_LEN(MAX_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // index of a character in "0123456789ABCDEF", -1 if absent
   function automatic int hex_index(input logic [7:0] b);
      for (int k = 0; k < 16; k++) begin
         if (hex_digits[k] == b) return k;
      end
      return -1;
   endfunction

   // Reads one sentence (seg[0] is '$') as text and reports the verdict, if any
   function automatic void model(input logic [7:0] seg[$], output bit found,
                                 output logic [1:0] e, output logic [7:0] c,
                                 output logic [7:0] r);
      int len;
      int part;   // 0 body, 1 first digit, 2 second digit, 3 want CR, 4 want LF
      int v;
      logic [7:0] b;
      found = 0; e = 2'd0; c = 8'h00; r = 8'h00;
      len = 1; part = 0;
      for (int i = 1; i < seg.size(); i++) begin
         b = seg[i];
         len++;
         if (part < 3 && len > MAX_LEN) begin
            found = 1; e = 2'd3; return;
         end
         if (part == 0) begin
            if (b == CH_STAR) part = 1;
            else if (b == CH_CR || b == CH_LF) begin found = 1; e = 2'd3; return; end
            else c = c ^ b;
         end else if (part == 1 || part == 2) begin
            v = hex_index(b);
            if (v < 0) begin found = 1; e = 2'd2; return; end
            if (part == 1) r = {4'(v), r[3:0]};
            else r = {r[7:4], 4'(v)};
            if (part == 2) begin
`ifdef NMEA_CRLF_CHECK_EN
               part = 3;
`else
               found = 1; e = (c == r) ? 2'd0 : 2'd1; return;
`endif
            end else begin
               part = 2;
            end
         end else if (part == 3) begin
            if (b == CH_CR) part = 4;
            else begin found = 1; e = 2'd3; return; end
         end else begin
            found = 1;
            e = (b == CH_LF) ? ((c == r) ? 2'd0 : 2'd1) : 2'd3;
            return;
         end
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_seg(input logic [7:0] seg[$], input int min_gap);
      foreach (seg[i]) send_byte(seg[i], $urandom_range(min_gap, 2));
   endtask

   // directed sentence with fixed expected verdict; crlf adds the terminator when it is checked
   task automatic run_dir(input string s, input bit crlf, input logic [7:0] extra,
                          input bit has_exp, input logic [1:0] e,
                          input logic [7:0] c, input logic [7:0] r, input int min_gap);
      logic [7:0] q[$];
      exp_t x;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      if (extra != 8'h00) q.push_back(extra);
`ifdef NMEA_CRLF_CHECK_EN
      if (crlf) begin q.push_back(CH_CR); q.push_back(CH_LF); end
`else
      if (crlf) begin end
`endif
      if (has_exp) begin
         x.e = e; x.c = c; x.r = r;
         exp_q.push_back(x);
      end
      send_seg(q, min_gap);
   endtask

   // verdict monitor
   always @(negedge clk) begin
      exp_t x;
      if (rst_n && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
         end else begin
            x = exp_q.pop_front();
            chk("err", {6'd0, bus.err}, {6'd0, x.e});
            chk("calc_sum", bus.calc_sum, x.c);
            chk("rx_sum", bus.rx_sum, x.r);
         end
      end
   end

   initial begin
      string charset;
      logic [7:0] seg[$];
      logic [7:0] sum;
      bit found;
      exp_t x;
      int n, mode, drop;

      hex_digits   = "0123456789ABCDEF";
      charset      = "ABCGNPRXZ0123,.";
      checks       = 0;
      failures     = 0;
      clk          = 1'b0;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // asynchronous reset state, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", {7'd0, bus.busy}, 8'h00);
      chk("rst_done", {7'd0, bus.done}, 8'h00);
      chk("rst_err", {6'd0, bus.err}, 8'h00);
      chk("rst_calc", bus.calc_sum, 8'h00);
      chk("rst_rx", bus.rx_sum, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_dir("$A*41", 1, 8'h00, 1, 2'd0, 8'h41, 8'h41, 0);
      run_dir("$AB*04", 1, 8'h00, 1, 2'd1, 8'h03, 8'h04, 0);
      run_dir("$A*4G", 0, 8'h00, 1, 2'd2, 8'h41, 8'h40, 0);
      run_dir("$A*4a", 0, 8'h00, 1, 2'd2, 8'h41, 8'h40, 0);
      run_dir("$X$A*41", 1, 8'h00, 1, 2'd0, 8'h41, 8'h41, 1);
      run_dir("$ABCDEFGH", 0, 8'h00, 1, 2'd3, 8'h40, 8'h00, 0);
      run_dir("$ABCD*04", 1, 8'h00, 1, 2'd0, 8'h04, 8'h04, 0);
      run_dir("$ABCDE*41", 0, 8'h00, 1, 2'd3, 8'h41, 8'h40, 0);
`ifdef NMEA_CRLF_CHECK_EN
      run_dir("$A*41X", 0, 8'h00, 1, 2'd3, 8'h41, 8'h41, 0);
`else
      run_dir("$A*41X", 0, 8'h00, 1, 2'd0, 8'h41, 8'h41, 0);
`endif
      run_dir("$AB", 0, CH_CR, 1, 2'd3, 8'h03, 8'h00, 0);

      // reset in mid-sentence: outputs drop at once, no verdict for "$AB"
      run_dir("$AB", 0, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0);
      chk("mid_busy", {7'd0, bus.busy}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {7'd0, bus.busy}, 8'h00);
      chk("mid_rst_err", {6'd0, bus.err}, 8'h00);
      chk("mid_rst_calc", bus.calc_sum, 8'h00);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_dir("$A*41", 1, 8'h00, 1, 2'd0, 8'h41, 8'h41, 0);

      // randomized sentences, some truncated, corrupted, overlong or trailed by junk
      for (int t = 0; t < 200; t++) begin
         seg.delete();
         seg.push_back(CH_DOLLAR);
         sum = 8'h00;
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 15) == 0) seg.push_back(CH_CR);
            else begin
               seg.push_back(charset[$urandom_range(0, charset.len() - 1)]);
               sum = sum ^ seg[seg.size() - 1];
            end
         end
         mode = $urandom_range(0, 9);
         if (mode < 8) begin
            seg.push_back(CH_STAR);
            if (mode == 5 || mode == 6) sum = 8'($urandom);
            seg.push_back(hex_digits[sum[7:4]]);
            seg.push_back(hex_digits[sum[3:0]]);
            if (mode == 7) seg[seg.size() - 1 - $urandom_range(0, 1)] = ($urandom_range(0, 1) != 0) ? 8'h67 : 8'h61;
         end
         if ($urandom_range(0, 5) == 0 && seg.size() > 2) begin
            drop = $urandom_range(1, 2);
            repeat (drop) void'(seg.pop_back());
         end
         if ($urandom_range(0, 1) != 0) begin seg.push_back(CH_CR); seg.push_back(CH_LF); end
         if ($urandom_range(0, 3) == 0) seg.push_back(8'h58);
         model(seg, found, x.e, x.c, x.r);
         if (found) exp_q.push_back(x);
         send_seg(seg, 0);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_verdicts", 8'(exp_q.size()), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nmea_checksum_ctrl.md
NMEA_CHECKSUM_CTRL -- requirements
Module: nmea_checksum_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 82: maximum accepted sentence length in bytes, counting from '$' through the last checksum digit.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_data carries a byte this cycle; there is no backpressure.
REQ-005 in_data  input  8  ASCII byte stream.
REQ-006 busy  output  1  high while a sentence is in progress, i.e. any state other than IDLE.
REQ-007 done  output  1  one-cycle pulse when a sentence verdict is issued.
REQ-008 err  output  2  verdict qualifier, valid with done: 0 ok, 1 checksum mismatch, 2 bad hex digit, 3 format or overflow.
REQ-009 calc_sum  output  8  XOR of all body bytes; held until the next '$'.
REQ-010 rx_sum  output  8  received checksum built from the two hex digits; held until the next '$'.

Function
REQ-011 States SHALL be IDLE, BODY, CK_HI, CK_LO, EOL and DONE, and only bytes with in_valid=1 advance the state.
REQ-012 IDLE: '$' clears calc_sum, rx_sum and the length counter, then moves to BODY; any other byte is ignored.
REQ-013 BODY: a byte other than '$', '*', CR or LF is XORed into calc_sum; '*' moves to CK_HI and is not XORed.
REQ-014 CK_HI/CK_LO: each byte is converted as one ASCII hex digit ('0'-'9' -> 0-9, 'A'-'F' -> 10-15, uppercase only) into rx_sum[7:4] and rx_sum[3:0] respectively.
REQ-015 A non-hex byte in CK_HI or CK_LO goes to DONE with err=2.
REQ-016 '$' in any non-IDLE state restarts the sentence exactly as in IDLE, and no done pulse is issued for the abandoned sentence.
REQ-017 CR or LF in BODY goes to DONE with err=3.
REQ-018 The length counter increments on every accepted byte, and exceeding MAX_LEN goes to DONE with err=3.
REQ-019 On a verdict without error, err SHALL be 0 if calc_sum == rx_sum and 1 otherwise.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE unconditionally; a '$' in the DONE cycle SHALL be handled as in IDLE, with no byte lost.
REQ-021 Latency: done is asserted on the cycle after the clock edge that accepted the deciding byte.
REQ-022 err SHALL hold its value until the next done pulse.
REQ-023 calc_sum, rx_sum and the counter widths are fixed; the counter is clog2(MAX_LEN+1) bits and saturates, it does not wrap.

Reset
REQ-024 rst_n low SHALL force state IDLE, busy=0, done=0, err=0, calc_sum=0x00, rx_sum=0x00 and counter=0 immediately, without waiting for clk.
REQ-025 Reset mid-sentence SHALL discard the sentence with no done pulse, and processing resumes at the first clk edge after rst_n goes high.

Configuration
REQ-026 Macro NMEA_CRLF_CHECK_EN defined: CK_LO moves to EOL, which requires CR then LF; the verdict is issued after LF, and any other byte in EOL goes to DONE with err=3 (a '$' restarts per REQ-016).
REQ-027 Macro NMEA_CRLF_CHECK_EN undefined: the EOL state does not exist, the verdict is issued after the CK_LO digit, and trailing bytes are ignored in IDLE.

Verification
REQ-028 Bytes "$A*41" (plus CR LF if the macro is on) -> done pulse once, err=0, calc_sum=0x41, rx_sum=0x41.
REQ-029 Bytes "$AB*04" -> err=1, calc_sum=0x03, rx_sum=0x04.
REQ-030 Bytes "$A*4G" -> done after 'G', err=2; "$A*4a" -> err=2.
REQ-031 Bytes "$X$A*41" with in_valid toggled low between bytes -> exactly one done, err=0, calc_sum=0x41.
REQ-032 MAX_LEN=8, bytes "$ABCDEFGH" -> done after 'H' (9th byte), err=3; rst_n pulsed low after "$AB" -> busy=0 immediately and no done pulse.
REQ-033 With the macro on, "$A*41" followed by 'X' -> err=3; with the macro off, "$A*41X" -> err=0 and 'X' is ignored.
